demux_12_buffer: RTL

DEMUX_12_BUFFER -- requirements
Module: demux_12_buffer

---
 rtl/demux_12_buffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/demux_12_buffer.sv
// demux_12_buffer: 1:2 demux feeding two show-ahead FIFO lanes, with per-lane overflow pulses.
// Optional macro DEMUX_ERR_CNT_EN enables the saturating error counter.
`default_nettype none

module demux_12_buffer #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    Reset_L,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    valid_in,
  input  logic                    sel_in,
  input  logic                    pop_A,
  input  logic                    pop_B,
  output logic [WIDTH-1:0]        data_A,
  output logic [WIDTH-1:0]        data_B,
  output logic                    valid_A,
  output logic                    valid_B,
  output logic [$clog2(DEPTH):0]  cnt_A,
  output logic [$clog2(DEPTH):0]  cnt_B,
  output logic                    ovf_A,
  output logic                    ovf_B,
  output logic [7:0]              err_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       drop;
  logic [1:0]       ovf;
  logic [CW-1:0]    cnt  [2];
  logic [WIDTH-1:0] head [2];

  // Lane 0 is A (sel_in=0), lane 1 is B (sel_in=1).
  assign push = {valid_in & sel_in, valid_in & ~sel_in};
  assign pop  = {pop_B, pop_A};

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             ovf_q;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop[l] & ~empty;
    // A pop in the same edge frees the slot, so a full lane still accepts the push.
    assign do_push = push[l] & (~full | do_pop);
    assign drop[l] = push[l] & full & ~pop[l];

    always_ff @(posedge clk or negedge Reset_L) begin
      if (!Reset_L) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        if (do_push && !do_pop)      count <= count + CW'(1);
        else if (do_pop && !do_push) count <= count - CW'(1);
        ovf_q <= drop[l];
      end
    end

    always_ff @(posedge clk) begin
      if (do_push && Reset_L) mem[wr_ptr] <= data_in;
    end

    assign head[l] = empty ? '0 : mem[rd_ptr];
    assign cnt[l]  = count;
    assign ovf[l]  = ovf_q;
  end

  assign data_A  = head[0];
  assign data_B  = head[1];
  assign cnt_A   = cnt[0];
  assign cnt_B   = cnt[1];
  assign valid_A = (cnt[0] != '0);
  assign valid_B = (cnt[1] != '0);
  assign ovf_A   = ovf[0];
  assign ovf_B   = ovf[1];

`ifdef DEMUX_ERR_CNT_EN
  logic [1:0] ign_pop;
  logic [1:0] n_ev;
  logic [8:0] err_sum;
  logic [7:0] err_q;

  assign ign_pop = pop & {cnt[1] == '0, cnt[0] == '0};
  // A lane cannot drop and ignore a pop in the same edge, so each lane adds at most one.
  assign n_ev    = {1'b0, drop[0] | ign_pop[0]} + {1'b0, drop[1] | ign_pop[1]};
  assign err_sum = {1'b0, err_q} + {7'd0, n_ev};

  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) err_q <= '0;
    else          err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

`default_nettype wire
